// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths and the 4-bit operation codes.
// The pipeline's control decoder imports this package too, so opcode values
// live in exactly one place.
package alu_pkg;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLL   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_SLT   = 4'b0111,
    ALU_SRA   = 4'b1000,
    ALU_NOR   = 4'b1001,
    ALU_SLTU  = 4'b1010,
    ALU_LUI   = 4'b1011,
    ALU_SLLV  = 4'b1100,
    ALU_SRLV  = 4'b1101,
    ALU_SRAV  = 4'b1110,
    ALU_PASSB = 4'b1111
  } alu_op_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter shared by the immediate and variable shifts.
// dir_right selects right shifts; arith sign-fills right shifts.
module alu_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic [WIDTH-1:0] data,
  input  logic [SHW-1:0]   amt,
  input  logic             dir_right,
  input  logic             arith,
  output logic [WIDTH-1:0] res
);

  // One extra top bit carries the fill value, so a single arithmetic right
  // shift covers both logical (fill 0) and arithmetic (fill sign) cases.
  logic signed [WIDTH:0] ext;
  logic signed [WIDTH:0] rsh;
  logic        [WIDTH-1:0] lsh;

  // Select shift direction and fill
  always_comb begin
    ext = {arith & data[WIDTH-1], data};
    rsh = ext >>> amt;
    lsh = data << amt;
    res = dir_right ? rsh[WIDTH-1:0] : lsh;
  end

endmodule

// File: rtl/alu.sv
// 32-bit execute-stage ALU: sixteen operations, registered result with zero
// and signed-overflow flags, one cycle of latency.
module alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       aluControl,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             overflow
);
  import alu_pkg::*;

  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic        [WIDTH-1:0] sum;
  logic        [WIDTH-1:0] diff;
  logic        [SHW-1:0]   sh_amt;
  logic                    sh_right;
  logic                    sh_arith;
  logic        [WIDTH-1:0] sh_res;
  logic        [WIDTH-1:0] res;
  logic                    ovf;
  logic        [WIDTH-1:0] out_p1;
  logic                    zero_p1;
  logic                    ovf_p1;

  assign a_s  = in1;
  assign b_s  = in2;
  assign sum  = in1 + in2;
  assign diff = in1 - in2;

  // Shifter controls: variable shifts take the amount from A[4:0]
  always_comb begin
    sh_amt   = shamt;
    sh_right = 1'b0;
    sh_arith = 1'b0;
    case (aluControl)
      ALU_SRL:  sh_right = 1'b1;
      ALU_SRA:  begin sh_right = 1'b1; sh_arith = 1'b1; end
      ALU_SLLV: sh_amt = in1[SHW-1:0];
      ALU_SRLV: begin sh_amt = in1[SHW-1:0]; sh_right = 1'b1; end
      ALU_SRAV: begin sh_amt = in1[SHW-1:0]; sh_right = 1'b1; sh_arith = 1'b1; end
      default:  ;
    endcase
  end

  alu_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
    .data      (in2),
    .amt       (sh_amt),
    .dir_right (sh_right),
    .arith     (sh_arith),
    .res       (sh_res)
  );

  // Result mux and overflow; SLT compares operands directly so it stays
  // correct when A-B would overflow
  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (aluControl)
      ALU_ADD:   begin res = sum;  ovf = add_ovf(in1[WIDTH-1], in2[WIDTH-1], sum[WIDTH-1]);  end
      ALU_SUB:   begin res = diff; ovf = sub_ovf(in1[WIDTH-1], in2[WIDTH-1], diff[WIDTH-1]); end
      ALU_AND:   res = in1 & in2;
      ALU_OR:    res = in1 | in2;
      ALU_XOR:   res = in1 ^ in2;
      ALU_NOR:   res = ~(in1 | in2);
      ALU_SLT:   res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU:  res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
      ALU_LUI:   res = {in2[15:0], 16'h0000};
      ALU_PASSB: res = in2;
      ALU_SLL, ALU_SRL, ALU_SRA,
      ALU_SLLV, ALU_SRLV, ALU_SRAV: res = sh_res;
      default:   res = '0;
    endcase
  end

  // Output register; reset forces a zero result with zero flag set
  always_ff @(posedge clk) begin
    if (rst) begin
      out_p1  <= '0;
      zero_p1 <= 1'b1;
      ovf_p1  <= 1'b0;
    end else begin
      out_p1  <= res;
      zero_p1 <= (res == '0);
      ovf_p1  <= ovf;
    end
  end

  assign out      = out_p1;
  assign zero     = zero_p1;
  assign overflow = ovf_p1;

endmodule

// File: tb/tb_alu.sv
// Testbench for alu: directed cases from the test plan, then randomized
// vectors checked against an arithmetic reference model.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [3:0]  aluControl;
  logic [4:0]  shamt;
  logic [31:0] out;
  logic        zero;
  logic        overflow;

  int n_vec;
  int n_err;

  alu dut (
    .clk        (clk),
    .rst        (rst),
    .in1        (in1),
    .in2        (in2),
    .aluControl (aluControl),
    .shamt      (shamt),
    .out        (out),
    .zero       (zero),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model from the operation table, using 64-bit signed arithmetic
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, output logic [31:0] r, output logic ov);
    longint sa;
    longint sb;
    longint s;
    logic [4:0] va;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    va = a[4:0];
    ov = 1'b0;
    r  = 32'h0;
    case (op)
      4'd0:  begin s = sa + sb; r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd1:  begin s = sa - sb; r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = b << sh;
      4'd6:  r = b >> sh;
      4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd8:  begin s = sb >>> sh; r = s[31:0]; end
      4'd9:  r = ~(a | b);
      4'd10: r = (a < b) ? 32'd1 : 32'd0;
      4'd11: r = {b[15:0], 16'h0000};
      4'd12: r = b << va;
      4'd13: r = b >> va;
      4'd14: begin s = sb >>> va; r = s[31:0]; end
      default: r = b;
    endcase
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    aluControl = op;
    in1 = a;
    in2 = b;
    shamt = sh;
    @(posedge clk);
    #1;
  endtask

  // Apply one operation and check all three outputs against the model
  task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] er;
    logic eo;
    model(op, a, b, sh, er, eo);
    drive(op, a, b, sh);
    chk({tag, ".out"}, out, er);
    chk({tag, ".zero"}, {31'b0, zero}, {31'b0, (er == 32'h0)});
    chk({tag, ".ovf"}, {31'b0, overflow}, {31'b0, eo});
  endtask

  // Apply one operation and check against hand-computed constants
  task automatic run_k(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh,
                       input logic [31:0] er, input logic eo);
    drive(op, a, b, sh);
    chk({tag, ".out"}, out, er);
    chk({tag, ".zero"}, {31'b0, zero}, {31'b0, (er == 32'h0)});
    chk({tag, ".ovf"}, {31'b0, overflow}, {31'b0, eo});
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'h0000_0000;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h7FFF_FFFF;
      3: v = 32'h8000_0000;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  logic [31:0] k_out [8];

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    in1 = 32'h0;
    in2 = 32'h0;
    aluControl = 4'h0;
    shamt = 5'h0;
    k_out = '{32'd6, 32'd2, 32'd0, 32'd6, 32'd6, 32'd8, 32'd0, 32'd0};

    // Reset held for two cycles
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst.out", out, 32'h0);
    chk("rst.zero", {31'b0, zero}, 32'd1);
    chk("rst.ovf", {31'b0, overflow}, 32'd0);
    rst = 1'b0;

    // Sweep the first eight opcodes on in1=4, in2=2, shamt=2
    for (int i = 0; i < 8; i++) begin
      run_k($sformatf("sweep%0d", i), 4'(i), 32'd4, 32'd2, 5'd2, k_out[i], 1'b0);
    end

    run_k("sub_eq",   4'd1,  32'd2,          32'd2,          5'd0,  32'h0,          1'b0);
    run_k("add_ovf",  4'd0,  32'h7FFF_FFFF,  32'd1,          5'd0,  32'h8000_0000,  1'b1);
    run_k("sub_ovf",  4'd1,  32'h8000_0000,  32'd1,          5'd0,  32'h7FFF_FFFF,  1'b1);
    run_k("slt_neg",  4'd7,  32'hFFFF_FFFF,  32'd1,          5'd0,  32'd1,          1'b0);
    run_k("sltu_big", 4'd10, 32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0,          1'b0);
    run_k("slt_ov",   4'd7,  32'h8000_0000,  32'h7FFF_FFFF,  5'd0,  32'd1,          1'b0);
    run_k("sra31",    4'd8,  32'h0,          32'h8000_0000,  5'd31, 32'hFFFF_FFFF,  1'b0);
    run_k("srav_a21", 4'd14, 32'h21,         32'h8000_0000,  5'd0,  32'hC000_0000,  1'b0);
    run_k("sll0",     4'd5,  32'h0,          32'hDEAD_BEEF,  5'd0,  32'hDEAD_BEEF,  1'b0);
    run_k("srl31",    4'd6,  32'h0,          32'h8000_0000,  5'd31, 32'h1,          1'b0);
    run_k("lui",      4'd11, 32'h0,          32'h1234_ABCD,  5'd0,  32'hABCD_0000,  1'b0);
    run_k("nor",      4'd9,  32'h0F0F_0000,  32'h0000_00F0,  5'd0,  32'hF0F0_FF0F,  1'b0);
    run_k("passb",    4'd15, 32'h5,          32'h0000_0042,  5'd7,  32'h0000_0042,  1'b0);
    run_k("sllv",     4'd12, 32'hFFFF_FFE4,  32'h1,          5'd0,  32'h10,         1'b0);

    // Reset asserted in the same cycle as an ADD: the sum must never appear
    run_k("pre_rst",  4'd0,  32'd10,         32'd20,         5'd0,  32'd30,         1'b0);
    rst = 1'b1;
    drive(4'd0, 32'h7FFF_FFFF, 32'd1, 5'd0);
    chk("mid_rst.out", out, 32'h0);
    chk("mid_rst.zero", {31'b0, zero}, 32'd1);
    chk("mid_rst.ovf", {31'b0, overflow}, 32'd0);
    rst = 1'b0;
    run_k("post_rst", 4'd0,  32'd3,          32'd4,          5'd0,  32'd7,          1'b0);

    // Randomized back-to-back operations
    for (int i = 0; i < 400; i++) begin
      run($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)), pick_operand(), pick_operand(),
          5'($urandom_range(0, 31)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
